maze_update_ctrl: RTL and testbench
===================================

Name: maze_update_ctrl

Overview:
Owns the write port of the 20-cell maze VGA RAM (9-bit cells, 5x4 grid, addr = row*5 + col). It receives Arduino cell updates on a 3-bit chunked bus with its own strobe, synchronizes them into the CLOCK_25 domain and assembles each 9-bit cell word. It also runs a clear sequencer that blanks the maze, and arbitrates the single RAM write port between clearing and Arduino updates. Sits between the GPIO_1 Arduino pins and the VGA_RAM write side; the VGA read side is untouched.

Parameters:
NUM_CELLS, 20, number of valid RAM cells (addresses 0..NUM_CELLS-1)
ADDR_W, 5, RAM/bus address width
CHUNK_W, 3, Arduino data chunk width; cell word = 3*CHUNK_W = 9 bits
SYNC_ADDR, 31, bus address value that marks start of frame
CLEAR_VALUE, 0, cell word written by the clear sequencer (unvisited, no walls, no treasure)

Ports:
CLOCK_25  in  1  system clock, 25 MHz
reset  in  1  asynchronous, active-high reset
ard_strobe  in  1  Arduino chunk strobe, asynchronous; rising edge = new chunk
ard_addr  in  ADDR_W  Arduino address, asynchronous, stable around strobe
ard_data  in  CHUNK_W  Arduino data chunk, asynchronous
clear_req  in  1  one-cycle pulse: blank the whole maze
ram_we  out  1  RAM write enable, one cycle per write
ram_waddr  out  ADDR_W  RAM write address
ram_wdata  out  9  RAM write data
busy  out  1  clear sequencer active
frame_err  out  1  one-cycle pulse on a protocol violation
overflow  out  1  sticky: an assembled cell was dropped
frames_count  out  8  number of Arduino cells written to RAM, wraps 255->0

Behaviour:
- All outputs registered. Reset values: ram_we=0, ram_waddr=0, ram_wdata=0, frame_err=0, overflow=0, frames_count=0, busy=1 (reset enters CLEAR at index 0).
- CDC: strobe, addr and data each pass through 2 flops. A rising edge on synchronized strobe gives strobe_pulse for one cycle, with addr/data sampled from the same stage. The Arduino holds addr/data stable for >=4 CLOCK_25 cycles after a strobe rising edge and keeps the strobe high for >=4 cycles.
- Framer FSM states: IDLE, C0, C1, C2.
  - IDLE: a strobe_pulse with addr==SYNC_ADDR goes to C0. Any other strobe_pulse is ignored, with no error.
  - C0/C1/C2, strobe_pulse with addr==SYNC_ADDR: go to C0 and discard partial data. frame_err pulses if the state was C1 or C2.
  - C0/C1/C2, strobe_pulse with addr>=NUM_CELLS and not SYNC_ADDR: frame_err pulses, go to IDLE.
  - C1/C2, strobe_pulse with addr different from the addr captured in C0: frame_err pulses, go to IDLE.
  - Otherwise capture the chunk: C0 fills word[2:0], C1 fills word[5:3], C2 fills word[8:6]. C0->C1->C2; C2 commits the cell and returns to IDLE. Each cell is preceded by its own sync marker.
- Pending buffer (one entry): a commit on C2 strobe_pulse in cycle T sets pending_valid in T+1.
  - If pending_valid is already set and not being drained in T, the new cell is dropped, overflow is set and the old entry is kept.
  - overflow clears only on reset or clear_req.
- Clear sequencer:
  - On reset or clear_req, idx=0 and busy=1.
  - Each cycle it writes CLEAR_VALUE to idx and increments idx. After idx=NUM_CELLS-1 is written, busy drops in the next cycle. A full clear takes NUM_CELLS cycles.
  - clear_req during a clear restarts at idx 0.
  - A clear_req in the same cycle as a pending drain wins: the pending entry is kept and drained after the clear.
- Arbiter: clear has strict priority. When busy=0 and pending_valid=1, the registered write is issued on the next cycle: ram_we=1, ram_waddr=captured addr, ram_wdata=word. pending_valid clears and frames_count increments on the same edge.
  - Latency from the C2 strobe_pulse (cycle T) to ram_we is T+2 when idle.
  - The Arduino framer keeps assembling during a clear.
- ram_we is never high for an address >= NUM_CELLS.

Decomposition:
- Package maze_pkg holds:
  - NUM_CELLS, SYNC_ADDR and CLEAR_VALUE
  - cell field positions: status [8:6], walls [5:2] (N,E,S,W from bit 5), treasure [1:0]
  - the framer state enum
- Sub-module strobe_sync: 2-flop synchronizers plus rising-edge detect. It outputs strobe_pulse, addr_s and data_s.

Test Plan:
- Reset release, no other stimulus -> writes to addresses 0..19 with data 0 on 20 consecutive cycles, busy=1 throughout, then busy=0, ram_we=0.
- After clear, send sync(31), then chunks data 5/3/1 at addr 7 -> one write with waddr=7, wdata=9'b001_011_101 at T+2, frames_count=1.
- Send sync, addr 7 data 5, then addr 8 -> frame_err pulse, no write. The next correct frame for addr 8 writes normally.
- Send sync, one chunk, then sync again -> frame_err pulse. The following three chunks for addr 2 write 9-bit value correctly.
- Complete a frame for addr 3 while busy (clear_req asserted 2 cycles earlier) -> write to 3 occurs exactly one cycle after busy falls. A second complete frame arriving while the first is still pending -> overflow=1, only the first is written.
- Assert reset mid-frame (state C1) -> outputs return to reset values immediately, clear restarts at idx 0, and the partial frame is never written.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared constants, cell field layout and framer state type for the maze RAM update path.
package maze_pkg;

  localparam int ADDR_W    = 5;
  localparam int CHUNK_W   = 3;
  localparam int WORD_W    = 3 * CHUNK_W;
  localparam int NUM_CELLS = 20;

  // Bus address that marks the start of a cell frame (not a RAM address).
  localparam logic [ADDR_W-1:0] SYNC_ADDR = ADDR_W'(31);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);
  // Clear index value one past the last cell; marks the end of a clear pass.
  localparam logic [ADDR_W-1:0] CELL_END  = ADDR_W'(NUM_CELLS);

  // Blank cell: unvisited, no walls, no treasure.
  localparam logic [WORD_W-1:0] CLEAR_VALUE = '0;

  // Cell word layout.
  localparam int STATUS_HI   = 8;
  localparam int STATUS_LO   = 6;
  localparam int WALLS_HI    = 5;
  localparam int WALLS_LO    = 2;
  localparam int WALL_N      = 5;
  localparam int WALL_E      = 4;
  localparam int WALL_S      = 3;
  localparam int WALL_W      = 2;
  localparam int TREASURE_HI = 1;
  localparam int TREASURE_LO = 0;

  // Arduino framer states: waiting for sync, then expecting chunk 0/1/2.
  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_C0   = 2'd1,
    FR_C1   = 2'd2,
    FR_C2   = 2'd3
  } framer_state_e;

  // True when the address names a real RAM cell.
  function automatic logic is_cell_addr(input logic [ADDR_W-1:0] a);
    return (a <= LAST_CELL);
  endfunction

endpackage

// File: rtl/maze_update_ctrl_strobe_sync.sv
// Brings the asynchronous Arduino strobe/addr/data into the CLOCK_25 domain and
// turns each rising strobe edge into a one-cycle pulse aligned with addr/data.
module strobe_sync
  import maze_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               strobe_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [CHUNK_W-1:0] data_i,
  output logic               strobe_pulse_o,
  output logic [ADDR_W-1:0]  addr_s_o,
  output logic [CHUNK_W-1:0] data_s_o
);

  logic [1:0]         strobe_q;
  logic               strobe_prev_q;
  logic [ADDR_W-1:0]  addr_m_q;
  logic [ADDR_W-1:0]  addr_s_q;
  logic [CHUNK_W-1:0] data_m_q;
  logic [CHUNK_W-1:0] data_s_q;

  // Two-flop synchronizers for every bus bit plus one flop of strobe history for edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strobe_q      <= '0;
      strobe_prev_q <= 1'b0;
      addr_m_q      <= '0;
      addr_s_q      <= '0;
      data_m_q      <= '0;
      data_s_q      <= '0;
    end else begin
      strobe_q      <= {strobe_q[0], strobe_i};
      strobe_prev_q <= strobe_q[1];
      addr_m_q      <= addr_i;
      addr_s_q      <= addr_m_q;
      data_m_q      <= data_i;
      data_s_q      <= data_m_q;
    end
  end

  // addr/data come from the same synchronizer depth as the strobe that qualifies them;
  // the Arduino holds them stable long enough that both have settled by the pulse.
  assign strobe_pulse_o = strobe_q[1] & ~strobe_prev_q;
  assign addr_s_o       = addr_s_q;
  assign data_s_o       = data_s_q;

endmodule

// File: rtl/maze_update_ctrl.sv
// Write-port owner for the maze VGA RAM: assembles Arduino cell frames, runs the
// clear sequencer and arbitrates the single RAM write port (clear has priority).
module maze_update_ctrl
  import maze_pkg::*;
(
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               ard_strobe,
  input  logic [ADDR_W-1:0]  ard_addr,
  input  logic [CHUNK_W-1:0] ard_data,
  input  logic               clear_req,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_waddr,
  output logic [WORD_W-1:0]  ram_wdata,
  output logic               busy,
  output logic               frame_err,
  output logic               overflow,
  output logic [7:0]         frames_count
);

  logic               strobe_pulse;
  logic [ADDR_W-1:0]  addr_s;
  logic [CHUNK_W-1:0] data_s;

  strobe_sync u_sync (
    .clk_i          (CLOCK_25),
    .rst_i          (reset),
    .strobe_i       (ard_strobe),
    .addr_i         (ard_addr),
    .data_i         (ard_data),
    .strobe_pulse_o (strobe_pulse),
    .addr_s_o       (addr_s),
    .data_s_o       (data_s)
  );

  // Framer state
  framer_state_e     state_q, state_d;
  logic [ADDR_W-1:0] cell_addr_q, cell_addr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              is_sync;
  logic              proto_err;
  logic              commit;
  logic [WORD_W-1:0] commit_word;

  // Pending buffer, clear sequencer and registered RAM-side outputs
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [WORD_W-1:0] pend_word_q, pend_word_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              overflow_q, overflow_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [7:0]        frames_q, frames_d;
  logic              frame_err_q, frame_err_d;
  logic              drain;

  assign is_sync     = (addr_s == SYNC_ADDR);
  // The third chunk is the top field; lower two chunks are already held in word_q.
  assign commit_word = {data_s, word_q[2*CHUNK_W-1:0]};

  // Framer state register.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_q     <= FR_IDLE;
      cell_addr_q <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      cell_addr_q <= cell_addr_d;
      word_q      <= word_d;
    end
  end

  // Framer next state: sync marker, three chunks for one address, then commit.
  always_comb begin
    state_d     = state_q;
    cell_addr_d = cell_addr_q;
    word_d      = word_q;
    proto_err   = 1'b0;
    commit      = 1'b0;
    if (strobe_pulse) begin
      if (state_q == FR_IDLE) begin
        // Stray chunks outside a frame are silently ignored.
        if (is_sync) state_d = FR_C0;
      end else if (is_sync) begin
        // Re-sync: restart the frame; only an error if chunks were already taken.
        state_d   = FR_C0;
        word_d    = '0;
        proto_err = (state_q != FR_C0);
      end else if (!is_cell_addr(addr_s)) begin
        state_d   = FR_IDLE;
        proto_err = 1'b1;
      end else if ((state_q != FR_C0) && (addr_s != cell_addr_q)) begin
        state_d   = FR_IDLE;
        proto_err = 1'b1;
      end else begin
        case (state_q)
          FR_C0: begin
            cell_addr_d              = addr_s;
            word_d[CHUNK_W-1:0]      = data_s;
            state_d                  = FR_C1;
          end
          FR_C1: begin
            word_d[2*CHUNK_W-1:CHUNK_W] = data_s;
            state_d                     = FR_C2;
          end
          default: begin
            commit  = 1'b1;
            state_d = FR_IDLE;
          end
        endcase
      end
    end
  end

  // Pending buffer, clear sequencer and write-port registers.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_word_q  <= '0;
      busy_q       <= 1'b1;
      clr_idx_q    <= '0;
      overflow_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      frames_q     <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_word_q  <= pend_word_d;
      busy_q       <= busy_d;
      clr_idx_q    <= clr_idx_d;
      overflow_q   <= overflow_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      frames_q     <= frames_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Arbitration: clear owns the port while busy; a pending cell drains only when idle
  // and not in a cycle where a new clear is being requested.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_word_d  = pend_word_q;
    busy_d       = busy_q;
    clr_idx_d    = clr_idx_q;
    overflow_d   = overflow_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    frames_d     = frames_q;
    frame_err_d  = proto_err;

    drain = pend_valid_q && !busy_q && !clear_req && is_cell_addr(pend_addr_q);

    if (drain) begin
      ram_we_d     = 1'b1;
      ram_waddr_d  = pend_addr_q;
      ram_wdata_d  = pend_word_q;
      pend_valid_d = 1'b0;
      frames_d     = frames_q + 8'd1;
    end

    // A new cell may take the slot being drained this cycle; otherwise keep the old one.
    if (commit) begin
      if (!pend_valid_q || drain) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = cell_addr_q;
        pend_word_d  = commit_word;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (clear_req) begin
      busy_d     = 1'b1;
      clr_idx_d  = '0;
      overflow_d = 1'b0;
    end else if (busy_q) begin
      if (clr_idx_q == CELL_END) begin
        busy_d = 1'b0;
      end else begin
        ram_we_d    = 1'b1;
        ram_waddr_d = clr_idx_q;
        ram_wdata_d = CLEAR_VALUE;
        clr_idx_d   = clr_idx_q + ADDR_W'(1);
      end
    end
  end

  assign ram_we       = ram_we_q;
  assign ram_waddr    = ram_waddr_q;
  assign ram_wdata    = ram_wdata_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;
  assign frames_count = frames_q;

endmodule

// File: tb/tb_maze_update_ctrl.sv
// Self-checking bench for maze_update_ctrl: clear sequence, frame assembly, protocol
// errors, busy/overflow interaction, reset mid-frame, randomized frames and counter wrap.
module tb_maze_update_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ard_strobe;
  logic [4:0] ard_addr;
  logic [2:0] ard_data;
  logic       clear_req;
  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [8:0] ram_wdata;
  logic       busy;
  logic       frame_err;
  logic       overflow;
  logic [7:0] frames_count;

  maze_update_ctrl dut (
    .CLOCK_25     (clk),
    .reset        (reset),
    .ard_strobe   (ard_strobe),
    .ard_addr     (ard_addr),
    .ard_data     (ard_data),
    .clear_req    (clear_req),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .busy         (busy),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .frames_count (frames_count)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [8:0] word;
  } wr_t;

  typedef struct {
    logic [4:0] addr;
    logic [2:0] d0;
    logic [2:0] d1;
    logic [2:0] d2;
    logic [8:0] word;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[6];

  int checks    = 0;
  int errors    = 0;
  int err_seen  = 0;
  int err_exp   = 0;
  int wr_seen   = 0;
  int exp_total = 0;
  int n_wr      = 0;
  int hold      = 6;

  int         lat, fall_at, wr_at, wr_before, rt, rk;
  logic       busy_prev;
  logic [4:0] ra, rb;
  logic [2:0] rd0, rd1, rd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [4:0] a, input logic [2:0] d, input bit clr);
    ard_addr   = a;
    ard_data   = d;
    ard_strobe = 1'b1;
    if (clr) begin
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      tick(hold - 1);
    end else begin
      tick(hold);
    end
    ard_strobe = 1'b0;
    tick(hold);
  endtask

  task automatic send_frame(input logic [4:0] a, input logic [2:0] d0, input logic [2:0] d1,
                            input logic [2:0] d2);
    send_chunk(5'd31, 3'd0, 1'b0);
    send_chunk(a, d0, 1'b0);
    send_chunk(a, d1, 1'b0);
    send_chunk(a, d2, 1'b0);
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [8:0] w);
    exp_q.push_back('{a, w});
    n_wr++;
    exp_total++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) tick(1);
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  // Cell word from its three chunks, lowest chunk first.
  function automatic logic [8:0] model_word(input logic [2:0] d0, input logic [2:0] d1,
                                            input logic [2:0] d2);
    return 9'(int'(d0) + 8 * int'(d1) + 64 * int'(d2));
  endfunction

  // Monitor: counts error pulses and checks every Arduino write against the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (ram_we && !busy) begin
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", ram_waddr, ram_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (ram_waddr !== mon_e.addr || ram_wdata !== mon_e.word) begin
            errors++;
            $display("FAIL write: got addr %0d data %0d, expected addr %0d data %0d",
                     ram_waddr, ram_wdata, mon_e.addr, mon_e.word);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no finish, expected finish within budget");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5'd0,  3'd7, 3'd0, 3'd0, 9'b000_000_111};
    vecs[1] = '{5'd19, 3'd0, 3'd0, 3'd7, 9'b111_000_000};
    vecs[2] = '{5'd7,  3'd5, 3'd3, 3'd1, 9'b001_011_101};
    vecs[3] = '{5'd12, 3'd2, 3'd4, 3'd6, 9'b110_100_010};
    vecs[4] = '{5'd5,  3'd1, 3'd2, 3'd3, 9'b011_010_001};
    vecs[5] = '{5'd19, 3'd7, 3'd7, 3'd7, 9'b111_111_111};

    reset      = 1'b1;
    ard_strobe = 1'b0;
    ard_addr   = 5'd0;
    ard_data   = 3'd0;
    clear_req  = 1'b0;
    #5;
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_waddr_wdata", 32'({ram_waddr, ram_wdata}), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_err_ovf_cnt", 32'({frame_err, overflow, frames_count}), 32'd0);

    // Clear after reset release: addresses 0..19 with zero data on consecutive cycles.
    tick(2);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("clear_write", 32'({busy, ram_we, ram_waddr, ram_wdata}), 32'({1'b1, 1'b1, 5'(k), 9'd0}));
    end
    tick(1);
    check("clear_done", 32'({busy, ram_we}), 32'd0);

    // First frame at addr 7 and its write latency from the last chunk.
    send_chunk(5'd31, 3'd0, 1'b0);
    send_chunk(5'd7, 3'd5, 1'b0);
    send_chunk(5'd7, 3'd3, 1'b0);
    expect_write(5'd7, 9'b001_011_101);
    ard_addr   = 5'd7;
    ard_data   = 3'd1;
    ard_strobe = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (lat < 0 && ram_we && !busy) lat = i;
    end
    ard_strobe = 1'b0;
    tick(hold);
    check("write_latency", 32'(lat), 32'd4);
    check("frames_after_first", 32'(frames_count), 32'd1);
    check("writes_after_first", 32'(wr_seen), 32'(exp_total));

    // Address change mid-frame -> error, no write; then a good frame for addr 8.
    send_chunk(5'd31, 3'd0, 1'b0);
    send_chunk(5'd7, 3'd5, 1'b0);
    send_chunk(5'd8, 3'd2, 1'b0);
    err_exp++;
    tick(2);
    check("addr_change_err", 32'(err_seen), 32'(err_exp));
    check("addr_change_nowrite", 32'(wr_seen), 32'(exp_total));
    expect_write(5'd8, 9'b100_010_110);
    send_frame(5'd8, 3'd6, 3'd2, 3'd4);
    tick(2);
    check("addr8_written", 32'(wr_seen), 32'(exp_total));

    // Re-sync after one chunk -> error; the following frame for addr 2 is intact.
    send_chunk(5'd31, 3'd0, 1'b0);
    send_chunk(5'd2, 3'd1, 1'b0);
    send_chunk(5'd31, 3'd0, 1'b0);
    err_exp++;
    expect_write(5'd2, 9'd52);
    send_chunk(5'd2, 3'd4, 1'b0);
    send_chunk(5'd2, 3'd6, 1'b0);
    send_chunk(5'd2, 3'd0, 1'b0);
    tick(2);
    check("resync_err", 32'(err_seen), 32'(err_exp));
    check("resync_written", 32'(wr_seen), 32'(exp_total));

    // Table-driven frames covering field extremes and boundary addresses.
    for (int v = 0; v < 6; v++) begin
      wr_before = wr_seen;
      expect_write(vecs[v].addr, vecs[v].word);
      send_frame(vecs[v].addr, vecs[v].d0, vecs[v].d1, vecs[v].d2);
      tick(2);
      check("vec_one_write", 32'(wr_seen - wr_before), 32'd1);
      check("vec_frames_count", 32'(frames_count), 32'(n_wr % 256));
    end

    // Frame completes during a clear, then a second frame overflows the pending slot.
    send_chunk(5'd31, 3'd0, 1'b0);
    send_chunk(5'd3, 3'd1, 1'b0);
    send_chunk(5'd3, 3'd2, 1'b0);
    expect_write(5'd3, 9'b011_010_001);
    send_chunk(5'd3, 3'd3, 1'b1);
    send_chunk(5'd31, 3'd0, 1'b1);
    send_chunk(5'd4, 3'd7, 1'b1);
    send_chunk(5'd4, 3'd7, 1'b1);
    send_chunk(5'd4, 3'd7, 1'b1);
    check("busy_during_frames", 32'(busy), 32'd1);
    fall_at   = -1;
    wr_at     = -1;
    busy_prev = busy;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (fall_at < 0 && busy_prev && !busy) fall_at = i;
      if (wr_at < 0 && ram_we && !busy) wr_at = i;
      busy_prev = busy;
    end
    check("busy_fell", 32'(fall_at > 0), 32'd1);
    check("write_after_busy", 32'(wr_at - fall_at), 32'd1);
    check("overflow_set", 32'(overflow), 32'd1);
    check("only_first_written", 32'(wr_seen), 32'(exp_total));
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'd0);
    wait_idle();

    // Reset while the framer is mid-frame.
    send_chunk(5'd31, 3'd0, 1'b0);
    send_chunk(5'd5, 3'd3, 1'b0);
    tick(1);
    reset = 1'b1;
    #1;
    check("midrst_outputs", 32'({ram_we, ram_waddr, ram_wdata, frame_err, overflow}), 32'd0);
    check("midrst_busy_cnt", 32'({busy, frames_count}), 32'({1'b1, 8'd0}));
    n_wr = 0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("midrst_clear_idx0", 32'({ram_we, ram_waddr}), 32'({1'b1, 5'd0}));
    wait_idle();
    wr_before = wr_seen;
    send_chunk(5'd5, 3'd4, 1'b0);
    send_chunk(5'd5, 3'd2, 1'b0);
    tick(4);
    check("midrst_no_write", 32'(wr_seen - wr_before), 32'd0);
    check("midrst_frames", 32'(frames_count), 32'd0);

    // Randomized frames, clean and corrupted, against the frame-level model.
    for (int f = 0; f < 40; f++) begin
      rt  = int'($urandom_range(0, 5));
      ra  = 5'($urandom_range(0, 19));
      rd0 = 3'($urandom_range(0, 7));
      rd1 = 3'($urandom_range(0, 7));
      rd2 = 3'($urandom_range(0, 7));
      case (rt)
        0: begin
          expect_write(ra, model_word(rd0, rd1, rd2));
          send_frame(ra, rd0, rd1, rd2);
        end
        1: begin
          rb = 5'((int'(ra) + 1 + int'($urandom_range(0, 29))) % 31);
          send_chunk(5'd31, 3'd0, 1'b0);
          send_chunk(ra, rd0, 1'b0);
          send_chunk(rb, rd1, 1'b0);
          err_exp++;
        end
        2: begin
          rk = int'($urandom_range(1, 2));
          send_chunk(5'd31, 3'd0, 1'b0);
          for (int c = 0; c < rk; c++) send_chunk(ra, 3'd7, 1'b0);
          err_exp++;
          expect_write(ra, model_word(rd0, rd1, rd2));
          send_frame(ra, rd0, rd1, rd2);
        end
        3: begin
          send_chunk(5'd31, 3'd0, 1'b0);
          send_chunk(5'($urandom_range(20, 30)), rd0, 1'b0);
          err_exp++;
        end
        4: begin
          send_chunk(5'($urandom_range(0, 30)), rd0, 1'b0);
        end
        default: begin
          send_chunk(5'd31, 3'd0, 1'b0);
          expect_write(ra, model_word(rd0, rd1, rd2));
          send_frame(ra, rd0, rd1, rd2);
        end
      endcase
      tick(2);
      check("rand_err", 32'(err_seen), 32'(err_exp));
      check("rand_writes", 32'(wr_seen), 32'(exp_total));
    end

    // Drive the Arduino write counter through its wrap.
    hold = 4;
    for (int g = 0; g < 400 && n_wr < 257; g++) begin
      ra  = 5'($urandom_range(0, 19));
      rd0 = 3'($urandom_range(0, 7));
      rd1 = 3'($urandom_range(0, 7));
      rd2 = 3'($urandom_range(0, 7));
      expect_write(ra, model_word(rd0, rd1, rd2));
      send_frame(ra, rd0, rd1, rd2);
      if (n_wr == 256) begin
        tick(4);
        check("frames_count_wrap", 32'(frames_count), 32'd0);
      end
    end
    tick(10);
    check("final_frames_count", 32'(frames_count), 32'(n_wr % 256));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_err", 32'(err_seen), 32'(err_exp));
    check("final_overflow", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
